// File: rtl/muldiv_sequencer_if.sv
// Handshake bundle between the main control FSM (master) and the MULT/DIV sequencer (slave).
interface muldiv_sequencer_if #(
    parameter int EXC_CODE_W = 2
);
    logic                  start;
    logic                  op_mult;
    logic                  divisor_zero;
    logic                  unit_done;
    logic                  abort;
    logic                  unit_start;
    logic                  unit_mode;
    logic                  busy;
    logic                  hilo_write;
    logic                  done;
    logic                  exc_req;
    logic [EXC_CODE_W-1:0] exc_code;
    logic                  epc_write;

    modport master (
        output start, op_mult, divisor_zero, unit_done, abort,
        input  unit_start, unit_mode, busy, hilo_write, done, exc_req, exc_code, epc_write
    );

    modport slave (
        input  start, op_mult, divisor_zero, unit_done, abort,
        output unit_start, unit_mode, busy, hilo_write, done, exc_req, exc_code, epc_write
    );
endinterface

// File: rtl/muldiv_sequencer.sv
// Multicycle MULT/DIV sequencer: issues the op, stalls main control for a counted
// (early-terminable, abortable) latency, then commits HI/LO or raises a divide-by-zero exception.
module muldiv_sequencer #(
    parameter int                    MULT_CYCLES = 32,
    parameter int                    DIV_CYCLES  = 32,
    parameter int                    CNT_W       = 6,
    parameter int                    EXC_CODE_W  = 2,
    parameter logic [EXC_CODE_W-1:0] DIV0_CODE   = 2'b10
) (
    input  logic               clk,
    input  logic               reset_in,
    muldiv_sequencer_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_RUN,
        S_WRITE,
        S_EXC
    } state_e;

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             mode_q, mode_d;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of the others, independent of statement order.
    always_ff @(posedge clk or posedge reset_in) begin
        if (reset_in) begin
            state_q <= S_IDLE;
            count_q <= '0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            mode_q  <= mode_d;
        end
    end

    // NOTE: every variable gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        mode_d  = mode_q;
        if (bus.abort) begin
            // Flush wins over any pending start or transition, including in IDLE.
            state_d = S_IDLE;
            count_d = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        mode_d  = bus.op_mult;
                        state_d = (!bus.op_mult && bus.divisor_zero) ? S_EXC : S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    count_d = mode_q ? MULT_LOAD : DIV_LOAD;
                    state_d = S_RUN;
                end
                S_RUN: begin
                    if (count_q == '0 || bus.unit_done) begin
                        state_d = S_WRITE;
                    end else begin
                        count_d = count_q - 1'b1;
                    end
                end
                S_WRITE: state_d = S_IDLE;
                S_EXC:   state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Moore outputs: decoded only from registered state and latched mode.
    always_comb begin
        bus.unit_start = 1'b0;
        bus.busy       = 1'b0;
        bus.hilo_write = 1'b0;
        bus.done       = 1'b0;
        bus.exc_req    = 1'b0;
        bus.exc_code   = '0;
        bus.epc_write  = 1'b0;
        unique case (state_q)
            S_IDLE:  ;
            S_ISSUE: begin
                bus.unit_start = 1'b1;
                bus.busy       = 1'b1;
            end
            S_RUN:   bus.busy = 1'b1;
            S_WRITE: begin
                bus.hilo_write = 1'b1;
                bus.done       = 1'b1;
                bus.busy       = 1'b1;
            end
            S_EXC: begin
                bus.exc_req   = 1'b1;
                bus.exc_code  = DIV0_CODE;
                bus.epc_write = 1'b1;
                bus.busy      = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.unit_mode = mode_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench: table of transactions on a 32/32-cycle instance with a scoreboard
// queue, plus hand sequences for reset, idle corner cases and 1/1-cycle back-to-back issue.
module tb_muldiv_sequencer;

    logic clk;
    logic reset_in;

    muldiv_sequencer_if #(.EXC_CODE_W(2)) bus_a ();
    muldiv_sequencer_if #(.EXC_CODE_W(2)) bus_b ();

    muldiv_sequencer #(
        .MULT_CYCLES(32), .DIV_CYCLES(32), .CNT_W(6), .EXC_CODE_W(2), .DIV0_CODE(2'b10)
    ) dut_a (
        .clk(clk), .reset_in(reset_in), .bus(bus_a)
    );

    muldiv_sequencer #(
        .MULT_CYCLES(1), .DIV_CYCLES(1), .CNT_W(6), .EXC_CODE_W(2), .DIV0_CODE(2'b10)
    ) dut_b (
        .clk(clk), .reset_in(reset_in), .bus(bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic op_mult;
        logic div_zero;
        int   done_cyc;     // cycle in which unit_done is high (0 = never)
        int   abort_cyc;    // cycle in which abort is high (0 = never)
        logic spam;         // hold start high while busy
        int   exp_busy;
        int   exp_done_cyc; // cycle of the done pulse (0 = none)
        int   exp_exc;
        int   exp_ustart;
    } vec_t;

    vec_t vecs[11];
    vec_t sb_q[$];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [8:0] outs_a();
        return {bus_a.unit_start, bus_a.unit_mode, bus_a.busy, bus_a.hilo_write,
                bus_a.done, bus_a.exc_req, bus_a.exc_code, bus_a.epc_write};
    endfunction

    function automatic logic [8:0] outs_b();
        return {bus_b.unit_start, bus_b.unit_mode, bus_b.busy, bus_b.hilo_write,
                bus_b.done, bus_b.exc_req, bus_b.exc_code, bus_b.epc_write};
    endfunction

    task automatic run_vec(input vec_t v, input int idx);
        int   cyc;
        int   busy_n, done_n, done_at, exc_n, us_n, us_at, bad_mode, bad_aux;
        vec_t exp;
        busy_n = 0; done_n = 0; done_at = 0; exc_n = 0;
        us_n = 0; us_at = 0; bad_mode = 0; bad_aux = 0;
        check($sformatf("v%0d_idle_before", idx), int'(bus_a.busy), 0);
        bus_a.start        = 1'b1;
        bus_a.op_mult      = v.op_mult;
        bus_a.divisor_zero = v.div_zero;
        sb_q.push_back(v);
        @(negedge clk);
        cyc = 1;
        while (bus_a.busy && cyc < 100) begin
            busy_n++;
            if (bus_a.done) begin
                done_n++;
                done_at = cyc;
            end
            if (bus_a.hilo_write != bus_a.done) bad_aux++;
            if (bus_a.exc_req) exc_n++;
            if (bus_a.epc_write != bus_a.exc_req) bad_aux++;
            if (bus_a.exc_code != (bus_a.exc_req ? 2'b10 : 2'b00)) bad_aux++;
            if (bus_a.unit_start) begin
                us_n++;
                us_at = cyc;
            end
            if (bus_a.unit_mode != v.op_mult) bad_mode++;
            bus_a.unit_done    = (cyc == v.done_cyc);
            bus_a.abort        = (cyc == v.abort_cyc);
            bus_a.start        = v.spam;
            bus_a.op_mult      = ~v.op_mult;
            bus_a.divisor_zero = ~v.div_zero;
            @(negedge clk);
            cyc++;
        end
        bus_a.unit_done = 1'b0;
        bus_a.abort     = 1'b0;
        bus_a.start     = 1'b0;
        check($sformatf("v%0d_timeout", idx), int'(cyc >= 100), 0);
        exp = sb_q.pop_front();
        check($sformatf("v%0d_busy_cycles", idx), busy_n, exp.exp_busy);
        check($sformatf("v%0d_done_cnt", idx), done_n, (exp.exp_done_cyc != 0) ? 1 : 0);
        check($sformatf("v%0d_done_cycle", idx), done_at, exp.exp_done_cyc);
        check($sformatf("v%0d_exc_cnt", idx), exc_n, exp.exp_exc);
        check($sformatf("v%0d_ustart_cnt", idx), us_n, exp.exp_ustart);
        check($sformatf("v%0d_ustart_cycle", idx), us_at, exp.exp_ustart);
        check($sformatf("v%0d_mode_err", idx), bad_mode, 0);
        check($sformatf("v%0d_aux_err", idx), bad_aux, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   b2b_busy[8];
        int   done_b;
        // op_mult div0 done abort spam | busy done_cyc exc ustart
        vecs[0]  = '{1'b1, 1'b0,  0,  0, 1'b0, 34, 34, 0, 1}; // MULT full length
        vecs[1]  = '{1'b0, 1'b1,  0,  0, 1'b0,  1,  0, 1, 0}; // DIV by zero
        vecs[2]  = '{1'b0, 1'b0,  6,  0, 1'b0,  7,  7, 0, 1}; // early done in 5th RUN cycle
        vecs[3]  = '{1'b0, 1'b0,  0, 11, 1'b1, 11,  0, 0, 1}; // abort in 10th RUN cycle
        vecs[4]  = '{1'b1, 1'b0,  1,  0, 1'b0, 34, 34, 0, 1}; // unit_done in ISSUE ignored
        vecs[5]  = '{1'b0, 1'b0, 33,  0, 1'b0, 34, 34, 0, 1}; // unit_done with count==0
        vecs[6]  = '{1'b1, 1'b0,  2,  0, 1'b0,  3,  3, 0, 1}; // done in first RUN cycle
        vecs[7]  = '{1'b1, 1'b0,  0,  1, 1'b0,  1,  0, 0, 1}; // abort in ISSUE
        vecs[8]  = '{1'b0, 1'b0,  0, 34, 1'b0, 34, 34, 0, 1}; // abort in WRITE still shows it
        vecs[9]  = '{1'b0, 1'b1,  0,  1, 1'b0,  1,  0, 1, 0}; // abort in EXC still shows it
        vecs[10] = '{1'b1, 1'b1,  0,  0, 1'b1, 34, 34, 0, 1}; // divisor_zero ignored for MULT

        reset_in = 1'b1;
        bus_a.start = 1'b0; bus_a.op_mult = 1'b0; bus_a.divisor_zero = 1'b0;
        bus_a.unit_done = 1'b0; bus_a.abort = 1'b0;
        bus_b.start = 1'b0; bus_b.op_mult = 1'b0; bus_b.divisor_zero = 1'b0;
        bus_b.unit_done = 1'b0; bus_b.abort = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_outs_a", int'(outs_a()), 0);
        check("reset_outs_b", int'(outs_b()), 0);
        reset_in = 1'b0;
        @(negedge clk);

        // Reset asserted between edges while in RUN.
        bus_a.start = 1'b1; bus_a.op_mult = 1'b1;
        @(negedge clk);
        bus_a.start = 1'b0;
        repeat (5) @(negedge clk);
        check("midrun_busy", int'(bus_a.busy), 1);
        check("midrun_mode", int'(bus_a.unit_mode), 1);
        #2 reset_in = 1'b1;
        #1 check("async_reset_outs", int'(outs_a()), 0);
        @(negedge clk);
        reset_in = 1'b0;
        @(negedge clk);
        check("post_reset_idle", int'(outs_a()), 0);

        // abort together with start in IDLE drops the start.
        bus_a.start = 1'b1; bus_a.abort = 1'b1; bus_a.op_mult = 1'b1;
        @(negedge clk);
        bus_a.start = 1'b0; bus_a.abort = 1'b0;
        check("idle_abort_beats_start", int'(bus_a.busy), 0);
        bus_a.unit_done = 1'b1;
        @(negedge clk);
        bus_a.unit_done = 1'b0;
        check("idle_unit_done_ignored", int'(bus_a.busy), 0);

        for (int i = 0; i < 11; i++) run_vec(vecs[i], i);
        check("scoreboard_empty", sb_q.size(), 0);

        // Back-to-back MULT then DIV with start held high, 1-cycle RUN.
        bus_b.start = 1'b1; bus_b.op_mult = 1'b1;
        done_b = 0;
        b2b_busy = '{0, 1, 1, 1, 0, 1, 1, 1};
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            if (c == 1) bus_b.op_mult = 1'b0;
            check($sformatf("b2b_busy_c%0d", c), int'(bus_b.busy), b2b_busy[c]);
            if (c <= 3) check($sformatf("b2b_mode_c%0d", c), int'(bus_b.unit_mode), 1);
            if (c >= 5) check($sformatf("b2b_mode_c%0d", c), int'(bus_b.unit_mode), 0);
            if (c == 1 || c == 5) check($sformatf("b2b_ustart_c%0d", c), int'(bus_b.unit_start), 1);
            if (bus_b.done) done_b++;
            if (c == 7) bus_b.start = 1'b0;
        end
        @(negedge clk);
        check("b2b_done_pulses", done_b, 2);
        check("b2b_idle_after", int'(bus_b.busy), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Parametrised multicycle sequencer for long-latency MULT/DIV instructions.
- Main control_unit FSM hands it a start pulse. The sequencer issues the operation to the DIV/MULT datapath and stalls the main FSM for a configurable latency, then commits HI/LO.
- Raises a division-by-zero exception request, with cause code and EPC write, instead of issuing a DIV with a zero divisor.
- Replaces the fixed, unimplemented "wait 32" behaviour with counted, early-terminable, abortable sequencing.

Parameters:
- MULT_CYCLES, 32, RUN-phase length for MULT (≥1).
- DIV_CYCLES, 32, RUN-phase length for DIV (≥1).
- CNT_W, 6, down-counter width; must hold max(MULT_CYCLES, DIV_CYCLES)-1.
- EXC_CODE_W, 2, width of exception cause code.
- DIV0_CODE, 2'b10, cause code driven on division by zero.

Ports:
- clk  input  1  system clock, rising edge.
- reset_in  input  1  asynchronous active-high reset.
- start  input  1  one-cycle request from main control; sampled only in IDLE.
- op_mult  input  1  operation select, sampled with start: 1=MULT, 0=DIV.
- divisor_zero  input  1  divisor (rt) equals zero, sampled with start.
- unit_done  input  1  early-completion flag from datapath; honoured only in RUN.
- abort  input  1  synchronous flush; returns to IDLE.
- unit_start  output  1  one-cycle start pulse to the DIV/MULT datapath.
- unit_mode  output  1  latched op_mult; stable from ISSUE through WRITE.
- busy  output  1  stall to main control.
- hilo_write  output  1  HI/LO register write enable.
- done  output  1  one-cycle completion pulse.
- exc_req  output  1  exception request to main control.
- exc_code  output  EXC_CODE_W  exception cause.
- epc_write  output  1  EPC register write enable.

Behaviour:
- Reset (async, reset_in=1):
  - State goes to IDLE and count to 0.
  - All outputs are 0, including unit_mode and exc_code.
  - Deasserting reset mid-operation leaves the block in IDLE; no pending write survives.
- All outputs are Moore-decoded from the registered state and latched mode; there are no combinational paths from inputs to outputs.
- States: IDLE, ISSUE, RUN, WRITE, EXC.
- Priority each edge: reset_in > abort > normal transition.
- IDLE:
  - busy=0.
  - If start=1: latch mode←op_mult.
    - If op_mult=0 and divisor_zero=1, go to EXC.
    - Otherwise go to ISSUE.
  - If start=0, stay in IDLE.
- ISSUE:
  - unit_start=1, busy=1.
  - Load count←(mode?MULT_CYCLES:DIV_CYCLES)-1, go to RUN.
- RUN:
  - busy=1.
  - If count==0 or unit_done=1, go to WRITE; otherwise count←count-1.
- WRITE:
  - hilo_write=1, done=1, busy=1, then go to IDLE.
- EXC:
  - exc_req=1, exc_code=DIV0_CODE, epc_write=1, busy=1, then go to IDLE.
  - hilo_write and unit_start stay 0.
- Latency, start sampled at edge E0 with no early done:
  - ISSUE occupies cycle 1.
  - RUN occupies cycles 2..N+1.
  - WRITE occupies cycle N+2.
  - Total busy cycles = N+2.
- Divide by zero: EXC occupies cycle 1 and busy lasts 1 cycle.
- start is ignored outside IDLE, including the WRITE/EXC cycle. The earliest back-to-back start is sampled at the edge ending WRITE+1 (first IDLE cycle).
- abort:
  - From any non-IDLE state, goes to IDLE at the next edge; count←0.
  - An aborted WRITE/EXC cycle still shows its outputs during that cycle, since outputs are state-decoded.
  - abort in IDLE together with start: abort wins and start is dropped.
- unit_done outside RUN has no effect.
- unit_done in the same cycle as count==0 gives a single WRITE.
- N=1: RUN lasts exactly one cycle.
- Counter never wraps. It is loaded only in ISSUE and decremented only while count>0.

Test Plan:
- Reset mid-RUN: assert reset_in asynchronously between edges -> all outputs 0 immediately; a later start behaves normally.
- MULT, MULT_CYCLES=32, unit_done=0: start=1, op_mult=1 -> unit_start high in cycle 1, unit_mode=1 through WRITE, busy high for 34 cycles, hilo_write=done=1 only in cycle 34.
- DIV with divisor_zero=1 -> cycle 1: exc_req=1, exc_code=2'b10, epc_write=1, busy=1, unit_start=0, hilo_write=0; cycle 2 IDLE.
- DIV, DIV_CYCLES=32, unit_done pulsed in the 5th RUN cycle (cycle 6) -> WRITE in cycle 7, done pulse once, unit_done in IDLE ignored.
- abort asserted in the 10th RUN cycle -> IDLE next cycle, no hilo_write/done at all; start re-asserted during RUN ignored; start in the first IDLE cycle accepted.
- Back-to-back: MULT then DIV with start held high continuously, MULT_CYCLES=DIV_CYCLES=1 -> busy pattern 1,1,1,0,1,1,1; unit_mode 1 then 0; two done pulses.
